// File: rtl/fifo_burst_drain_pkg.sv
// fifo_burst_drain_pkg: shared types and constants for the burst drain block.
// Holds the FSM state encoding and the width of the optional burst counter.
package fifo_burst_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_t;

  // Width of the o_nBursts statistics counter (FIFO_BURST_DRAIN_STATS_EN builds).
  localparam int STATS_W = 16;

endpackage

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: pulls words from an upstream fifo and sends them
// downstream as bursts of [length header][len data words].
// A burst starts once MAXBURST words are waiting, or after TIMEOUT idle
// cycles with a partial fifo. The body is a combinational pass-through, so
// back-pressure from downstream reaches the upstream pop strobe directly.
// Optional macro FIFO_BURST_DRAIN_STATS_EN adds a 16-bit o_nBursts counter.
module fifo_burst_drain
  import fifo_burst_drain_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int MAXBURST = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [$clog2(DEPTH+1)-1:0] i_nEntries,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       i_ready
`ifdef FIFO_BURST_DRAIN_STATS_EN
  ,
  output logic [STATS_W-1:0]         o_nBursts
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LEN_W = $clog2(MAXBURST + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MAXB_C    = CNT_W'(MAXBURST);
  localparam logic [LEN_W-1:0] MAXB_LEN  = LEN_W'(MAXBURST);
  localparam logic [TMR_W-1:0] TIMEOUT_C = TMR_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             trigger;

  // A full burst is waiting, or a partial one has sat for TIMEOUT cycles.
  assign trigger = (i_nEntries >= MAXB_C) || (i_valid && (timer_q == TIMEOUT_C));

  // State and burst bookkeeping registers; everything holds while i_cg is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else if (i_cg) begin
      state_q <= state_d;
      timer_q <= timer_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic and handshake outputs for IDLE / HEADER / BODY.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    len_d   = len_q;
    rem_d   = rem_q;
    o_valid = 1'b0;
    o_ready = 1'b0;
    o_data  = '0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          len_d   = (i_nEntries >= MAXB_C) ? MAXB_LEN : LEN_W'(i_nEntries);
          timer_d = '0;
          state_d = HEADER;
        end else if (!i_valid) begin
          timer_d = '0;
        end else if (timer_q != TIMEOUT_C) begin
          // Saturate rather than wrap so a stalled partial burst still fires.
          timer_d = timer_q + 1'b1;
        end
      end
      HEADER: begin
        o_valid = 1'b1;
        o_data  = WIDTH'(len_q);
        if (i_ready) begin
          rem_d   = len_q;
          state_d = BODY;
        end
      end
      BODY: begin
        o_data  = i_data;
        o_valid = i_valid;
        o_ready = i_ready;
        if (i_valid && i_ready) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_BURST_DRAIN_STATS_EN
  logic [STATS_W-1:0] bursts_q;

  // Count accepted headers; wraps naturally at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bursts_q <= '0;
    end else if (i_cg && (state_q == HEADER) && i_ready) begin
      bursts_q <= bursts_q + 1'b1;
    end
  end

  assign o_nBursts = bursts_q;
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: directed bench for fifo_burst_drain with default
// parameters (WIDTH 8, DEPTH 8, MAXBURST 4, TIMEOUT 15). A queue models the
// upstream fifo; downstream transfers are logged with their cycle number.
// Define FIFO_BURST_DRAIN_STATS_EN to also exercise o_nBursts.
module tb_fifo_burst_drain;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cg = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_nEntries = '0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b1;
`ifdef FIFO_BURST_DRAIN_STATS_EN
  logic [15:0] o_nBursts;
`endif

  logic [7:0] fifo_q[$];
  logic [7:0] out_q[$];
  int         out_cyc[$];
  int         cyc;
  int         n_pops;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       s_valid, s_ready;
  logic [7:0] s_data;

  fifo_burst_drain dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_nEntries (i_nEntries),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
`ifdef FIFO_BURST_DRAIN_STATS_EN
    ,
    .o_nBursts  (o_nBursts)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic drive_inputs();
    i_valid    = (fifo_q.size() > 0);
    i_data     = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    i_nEntries = 4'(fifo_q.size());
  endtask

  // One clock cycle: sample at negedge, apply pops/new inputs just after posedge.
  task automatic cycle();
    logic pop;
    @(negedge i_clk);
    s_valid = o_valid;
    s_data  = o_data;
    s_ready = o_ready;
    if (o_valid && i_ready && i_cg) begin
      out_q.push_back(o_data);
      out_cyc.push_back(cyc);
      $display("xfer cyc=%0d data=%02h", cyc, o_data);
    end
    pop = o_ready && i_valid && i_cg;
    @(posedge i_clk);
    #1;
    cyc++;
    if (pop) begin
      fifo_q.delete(0);
      n_pops++;
    end
    drive_inputs();
  endtask

  task automatic clear_log();
    out_q.delete();
    out_cyc.delete();
    cyc    = 0;
    n_pops = 0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_cg  = 1'b1;
    drive_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_inputs();
    clear_log();
  endtask

  task automatic test_reset();
    fifo_q.delete();
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h10 + 8'(i));
    i_rst = 1'b1;
    drive_inputs();
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    n_cmp++; if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h want 00", o_data); end
    fifo_q.delete();
    do_reset();
    cycle();
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", s_valid); end
  endtask

  task automatic test_full_burst();
    logic [7:0] exp_d[5];
    int         exp_c[5];
    exp_d = '{8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp_c = '{1, 2, 3, 4, 5};
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + 8'(i));
    drive_inputs();
    repeat (8) cycle();
    n_cmp++; if (out_q.size() != 5) begin n_err++; $display("FAIL full_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_d[i] || out_cyc[i] != exp_c[i]) begin
        n_err++;
        $display("FAIL full_word%0d: got %02h@%0d want %02h@%0d", i, out_q[i], out_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    n_cmp++; if (n_pops != 4) begin n_err++; $display("FAIL full_pops: got %0d want 4", n_pops); end
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL full_idle: got %b want 0", s_valid); end
  endtask

  task automatic test_timeout();
    fifo_q.delete();
    do_reset();
    fifo_q.push_back(8'h55);
    drive_inputs();
    repeat (20) cycle();
    n_cmp++; if (out_q.size() != 2) begin n_err++; $display("FAIL tmo_count: got %0d want 2", out_q.size()); end
    if (out_q.size() == 2) begin
      n_cmp++; if (out_q[0] !== 8'h01 || out_cyc[0] != 16) begin n_err++; $display("FAIL tmo_header: got %02h@%0d want 01@16", out_q[0], out_cyc[0]); end
      n_cmp++; if (out_q[1] !== 8'h55 || out_cyc[1] != 17) begin n_err++; $display("FAIL tmo_data: got %02h@%0d want 55@17", out_q[1], out_cyc[1]); end
    end
    n_cmp++; if (n_pops != 1) begin n_err++; $display("FAIL tmo_pops: got %0d want 1", n_pops); end
  endtask

  task automatic test_split();
    logic [7:0] exp_d[8];
    int         exp_c[8];
    exp_d = '{8'h04, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h02, 8'hB4, 8'hB5};
    exp_c = '{1, 2, 3, 4, 5, 22, 23, 24};
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hB0 + 8'(i));
    drive_inputs();
    repeat (28) cycle();
    n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL split_count: got %0d want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_d[i] || out_cyc[i] != exp_c[i]) begin
        n_err++;
        $display("FAIL split_word%0d: got %02h@%0d want %02h@%0d", i, out_q[i], out_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    n_cmp++; if (n_pops != 6) begin n_err++; $display("FAIL split_pops: got %0d want 6", n_pops); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[5];
    int         exp_c[5];
    exp_d = '{8'h04, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    exp_c = '{6, 7, 8, 14, 15};
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC0 + 8'(i));
    i_ready = 1'b0;
    drive_inputs();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== 8'h04 || s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_header%0d: got v=%b d=%02h r=%b want v=1 d=04 r=0", i, s_valid, s_data, s_ready);
      end
    end
    i_ready = 1'b1;
    repeat (3) cycle();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== 8'hC2 || s_ready !== 1'b0 || n_pops != 2) begin
        n_err++;
        $display("FAIL bp_body%0d: got v=%b d=%02h r=%b pops=%0d want v=1 d=c2 r=0 pops=2", i, s_valid, s_data, s_ready, n_pops);
      end
    end
    i_ready = 1'b1;
    repeat (4) cycle();
    n_cmp++; if (out_q.size() != 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_d[i] || out_cyc[i] != exp_c[i]) begin
        n_err++;
        $display("FAIL bp_word%0d: got %02h@%0d want %02h@%0d", i, out_q[i], out_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    n_cmp++; if (n_pops != 4) begin n_err++; $display("FAIL bp_pops: got %0d want 4", n_pops); end
  endtask

  task automatic test_reset_mid_burst();
    int pops_before;
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hD0 + 8'(i));
    drive_inputs();
    repeat (4) cycle();
    pops_before = n_pops;
    n_cmp++; if (pops_before != 2) begin n_err++; $display("FAIL mid_pre_pops: got %0d want 2", pops_before); end
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_async: got v=%b r=%b d=%02h want 0 0 00", o_valid, o_ready, o_data);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_inputs();
    clear_log();
    repeat (20) cycle();
    n_cmp++; if (out_q.size() != 3) begin n_err++; $display("FAIL mid_count: got %0d want 3", out_q.size()); end
    if (out_q.size() == 3) begin
      n_cmp++; if (out_q[0] !== 8'h02 || out_cyc[0] != 16) begin n_err++; $display("FAIL mid_header: got %02h@%0d want 02@16", out_q[0], out_cyc[0]); end
      n_cmp++; if (out_q[1] !== 8'hD2 || out_q[2] !== 8'hD3) begin n_err++; $display("FAIL mid_data: got %02h %02h want d2 d3", out_q[1], out_q[2]); end
    end
    n_cmp++; if (pops_before + n_pops != 4) begin n_err++; $display("FAIL mid_pops: got %0d want 4", pops_before + n_pops); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d[10];
    int         exp_c[10];
    exp_d = '{8'h04, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'h04, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
    exp_c = '{1, 2, 3, 4, 5, 7, 8, 9, 10, 11};
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hE0 + 8'(i));
    drive_inputs();
    repeat (14) cycle();
    n_cmp++; if (out_q.size() != 10) begin n_err++; $display("FAIL b2b_count: got %0d want 10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_d[i] || out_cyc[i] != exp_c[i]) begin
        n_err++;
        $display("FAIL b2b_word%0d: got %02h@%0d want %02h@%0d", i, out_q[i], out_cyc[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_clock_gate();
    logic [7:0] exp_d[5];
    int         exp_c[5];
    exp_d = '{8'h04, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
    exp_c = '{1, 2, 7, 8, 9};
    // Freeze mid-body.
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hF0 + 8'(i));
    drive_inputs();
    repeat (3) cycle();
    i_cg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== 8'hF1 || n_pops != 1 || out_q.size() != 2) begin
        n_err++;
        $display("FAIL cg_body%0d: got v=%b d=%02h pops=%0d outs=%0d want v=1 d=f1 pops=1 outs=2", i, s_valid, s_data, n_pops, out_q.size());
      end
    end
    i_cg = 1'b1;
    repeat (6) cycle();
    n_cmp++; if (out_q.size() != 5) begin n_err++; $display("FAIL cg_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_d[i] || out_cyc[i] != exp_c[i]) begin
        n_err++;
        $display("FAIL cg_word%0d: got %02h@%0d want %02h@%0d", i, out_q[i], out_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    // Freeze the idle timer: 4 gated cycles push the timeout header out by 4.
    fifo_q.delete();
    do_reset();
    fifo_q.push_back(8'h5A);
    drive_inputs();
    repeat (5) cycle();
    i_cg = 1'b0;
    repeat (4) cycle();
    i_cg = 1'b1;
    repeat (14) cycle();
    n_cmp++;
    if (out_q.size() != 2 || out_q[0] !== 8'h01 || out_cyc[0] != 20) begin
      n_err++;
      $display("FAIL cg_timer: got n=%0d first=%02h@%0d want n=2 first=01@20", out_q.size(), out_q[0], out_cyc[0]);
    end
  endtask

  task automatic test_stats();
`ifdef FIFO_BURST_DRAIN_STATS_EN
    fifo_q.delete();
    do_reset();
    n_cmp++; if (o_nBursts !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d want 0", o_nBursts); end
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) fifo_q.push_back(8'(b * 16 + i));
      drive_inputs();
      repeat (7) cycle();
    end
    n_cmp++; if (o_nBursts !== 16'd3) begin n_err++; $display("FAIL stats_three: got %0d want 3", o_nBursts); end
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h70 + 8'(i));
    drive_inputs();
    cycle();
    i_cg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (o_nBursts !== 16'd3 || s_valid !== 1'b1 || s_data !== 8'h04) begin
        n_err++;
        $display("FAIL stats_frozen%0d: got n=%0d v=%b d=%02h want n=3 v=1 d=04", i, o_nBursts, s_valid, s_data);
      end
    end
    i_cg = 1'b1;
    repeat (7) cycle();
    n_cmp++; if (o_nBursts !== 16'd4) begin n_err++; $display("FAIL stats_four: got %0d want 4", o_nBursts); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_split();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    test_clock_gate();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
